// File: rtl/move_reg_scroll_pkg.sv
// rtl/move_reg_scroll_pkg.sv - shared mode encodings for the digit scroll register
// Shared with the keypad/control FSM so both sides agree on Mode values and the dark-digit code.
package move_reg_pkg;

  localparam logic [2:0] MODE_CLEAR    = 3'b000;
  localparam logic [2:0] MODE_SHIFT_UP = 3'b001;
  localparam logic [2:0] MODE_SHIFT_DN = 3'b010;
  localparam logic [2:0] MODE_HOLD     = 3'b011;
  localparam logic [2:0] MODE_ROT_UP   = 3'b100;
  localparam logic [2:0] MODE_ROT_DN   = 3'b101;
  localparam logic [2:0] MODE_LOAD     = 3'b110;
  localparam logic [2:0] MODE_AUTO     = 3'b111;

  localparam int BLANK_CODE = 10;

endpackage

// File: rtl/move_reg_scroll_if.sv
// rtl/move_reg_scroll_if.sv - control/data bundle between control FSM, scroll register and scanner
// master drives mode and data; slave returns the registered digits and status.
interface move_reg_scroll_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int FW = $clog2(DEPTH + 1);

  logic                   en;
  logic [2:0]             Mode;
  logic [WIDTH-1:0]       DinL;
  logic [WIDTH-1:0]       DinR;
  logic [WIDTH*DEPTH-1:0] Dpar;
  logic [WIDTH*DEPTH-1:0] Dout;
  logic [FW-1:0]          fill;
  logic                   full;
  logic                   scroll_tick;

  modport master (
    output en, Mode, DinL, DinR, Dpar,
    input  Dout, fill, full, scroll_tick
  );

  modport slave (
    input  en, Mode, DinL, DinR, Dpar,
    output Dout, fill, full, scroll_tick
  );

endinterface

// File: rtl/move_reg_scroll_div.sv
// rtl/move_reg_scroll_div.sv - auto-scroll divider and step tick
// step is combinational so the rotate lands on the same edge that raises the registered tick.
module scroll_div #(
  parameter int SCROLL_DIV = 4
) (
  input  logic clkm,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic step,
  output logic tick
);
  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [CW-1:0] cnt;

  assign step = run && !clr && (cnt == CW'(SCROLL_DIV - 1));

  always_ff @(posedge clkm or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (run) begin
      if (step) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/move_reg_scroll.sv
// rtl/move_reg_scroll.sv - digit shift/rotate register with fill tracking and marquee scroll
// Feeds the multiplexed 7-seg scanner; slot i is Dout[i*WIDTH +: WIDTH].
module move_reg_scroll
  import move_reg_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 8,
  parameter int BLANK      = BLANK_CODE,
  parameter int SCROLL_DIV = 4
) (
  input  logic              clkm,
  input  logic              rst,
  move_reg_scroll_if.slave  bus
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]       slot [DEPTH];
  logic [WIDTH*DEPTH-1:0] dout;
  logic [FW-1:0]          fill_q;
  logic [FW-1:0]          fill_nxt;
  logic                   full_q;
  logic                   step;
  logic                   tick;
  logic                   is_clear;

  assign is_clear = (bus.Mode == MODE_CLEAR);

  scroll_div #(.SCROLL_DIV(SCROLL_DIV)) u_div (
    .clkm (clkm),
    .rst  (rst),
    .run  ((bus.Mode == MODE_AUTO) && bus.en),
    .clr  (bus.Mode != MODE_AUTO),
    .step (step),
    .tick (tick)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam int P = (i + DEPTH - 1) % DEPTH;
    localparam int N = (i + 1) % DEPTH;
    logic [WIDTH-1:0] nxt;

    always_comb begin
      nxt = slot[i];
      if (is_clear) begin
        nxt = WIDTH'(BLANK);
      end else if (bus.en) begin
        case (bus.Mode)
          MODE_SHIFT_UP: nxt = (i == 0) ? bus.DinL : slot[P];
          MODE_SHIFT_DN: nxt = (i == DEPTH - 1) ? bus.DinR : slot[N];
          MODE_ROT_UP:   nxt = slot[P];
          MODE_ROT_DN:   nxt = slot[N];
          MODE_LOAD:     nxt = bus.Dpar[i*WIDTH +: WIDTH];
          MODE_AUTO:     nxt = step ? slot[P] : slot[i];
          default:       nxt = slot[i];
        endcase
      end
    end

    always_ff @(posedge clkm or posedge rst) begin
      if (rst) slot[i] <= WIDTH'(BLANK);
      else     slot[i] <= nxt;
    end
  end

  // fill counts shift events, not non-blank content
  always_comb begin
    fill_nxt = fill_q;
    if (is_clear) begin
      fill_nxt = '0;
    end else if (bus.en) begin
      case (bus.Mode)
        MODE_SHIFT_UP, MODE_SHIFT_DN:
          fill_nxt = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;
        MODE_LOAD: fill_nxt = FW'(DEPTH);
        default:   fill_nxt = fill_q;
      endcase
    end
  end

  always_ff @(posedge clkm or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_nxt;
      full_q <= (fill_nxt == FW'(DEPTH));
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) dout[i*WIDTH +: WIDTH] = slot[i];
  end

  assign bus.Dout        = dout;
  assign bus.fill        = fill_q;
  assign bus.full        = full_q;
  assign bus.scroll_tick = tick;

endmodule

// File: tb/tb_move_reg_scroll.sv
// tb/tb_move_reg_scroll.sv - self-checking bench for move_reg_scroll
// Directed scenarios followed by random traffic, all checked against an array-based model.
module tb_move_reg_scroll;
  import move_reg_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;

  logic clkm = 1'b0;
  logic rst  = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  move_reg_scroll_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  move_reg_scroll #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BLANK(10), .SCROLL_DIV(DIV)) dut (
    .clkm (clkm),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clkm = ~clkm;

  int m_slot [DEPTH];
  int m_fill;
  int m_div;
  bit m_tick;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v = v | (32'(m_slot[i] & 15) << (4 * i));
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_slot[i] = 10;
    m_fill = 0;
    m_div  = 0;
    m_tick = 0;
  endtask

  task automatic m_rotate(input int dir);
    int t[DEPTH];
    for (int i = 0; i < DEPTH; i++) t[i] = m_slot[i];
    for (int i = 0; i < DEPTH; i++) m_slot[i] = t[(i - dir + DEPTH) % DEPTH];
  endtask

  task automatic m_edge(input logic [2:0] md, input bit e, input int dl, input int dr,
                        input logic [31:0] dp);
    m_tick = 0;
    if (md == MODE_CLEAR) begin
      m_reset();
    end else begin
      if (md != MODE_AUTO) m_div = 0;
      if (e) begin
        case (md)
          MODE_SHIFT_UP: begin m_rotate(1);  m_slot[0] = dl;         m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH; end
          MODE_SHIFT_DN: begin m_rotate(-1); m_slot[DEPTH-1] = dr;   m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH; end
          MODE_ROT_UP:   m_rotate(1);
          MODE_ROT_DN:   m_rotate(-1);
          MODE_LOAD: begin
            for (int i = 0; i < DEPTH; i++) m_slot[i] = int'((dp >> (4 * i)) & 32'hF);
            m_fill = DEPTH;
          end
          MODE_AUTO: begin
            if (m_div == DIV - 1) begin m_rotate(1); m_div = 0; m_tick = 1; end
            else m_div++;
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, 64'(bus.Dout), 64'(m_pack()));
    chk({tag, ".fill"}, 64'(bus.fill), 64'(m_fill));
    chk({tag, ".full"}, 64'(bus.full), 64'(m_fill == DEPTH));
    chk({tag, ".tick"}, 64'(bus.scroll_tick), 64'(m_tick));
  endtask

  task automatic cyc(input string tag, input logic [2:0] md, input bit e,
                     input int dl = 0, input int dr = 0, input logic [31:0] dp = '0);
    bus.Mode = md;
    bus.en   = e;
    bus.DinL = WIDTH'(dl);
    bus.DinR = WIDTH'(dr);
    bus.Dpar = dp;
    @(posedge clkm);
    m_edge(md, e, dl, dr, dp);
    @(negedge clkm);
    check_all(tag);
  endtask

  initial begin
    bus.Mode = MODE_HOLD;
    bus.en   = 1'b0;
    bus.DinL = '0;
    bus.DinR = '0;
    bus.Dpar = '0;
    m_reset();
    repeat (2) @(negedge clkm);
    rst = 1'b0;
    check_all("reset");
    chk("reset.const", 64'(bus.Dout), 64'h0000_0000_AAAA_AAAA);

    for (int k = 1; k <= 9; k++) cyc("shup", MODE_SHIFT_UP, 1'b1, k);
    chk("shup.const", 64'(bus.Dout), 64'h2345_6789);

    // asynchronous reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    chk("arst.dout", 64'(bus.Dout), 64'hAAAA_AAAA);
    chk("arst.fill", 64'(bus.fill), 64'd0);
    chk("arst.full", 64'(bus.full), 64'd0);
    @(negedge clkm);
    rst = 1'b0;
    m_reset();

    for (int k = 0; k < 6; k++) cyc("shdn", MODE_SHIFT_DN, (k % 2) == 0, 0, 5);
    chk("shdn.const", 64'(bus.Dout), 64'h555A_AAAA);
    chk("shdn.fill", 64'(bus.fill), 64'd3);

    cyc("load", MODE_LOAD, 1'b1, 0, 0, 32'h7654_3210);
    cyc("rotdn", MODE_ROT_DN, 1'b1);
    chk("rotdn.const", 64'(bus.Dout), 64'h0765_4321);
    cyc("rotup", MODE_ROT_UP, 1'b1);
    chk("rotup.const", 64'(bus.Dout), 64'h7654_3210);

    for (int k = 0; k < 9; k++) cyc("auto", MODE_AUTO, 1'b1);
    for (int k = 0; k < 2; k++) cyc("hold", MODE_HOLD, 1'b1);
    for (int k = 0; k < 5; k++) cyc("auto2", MODE_AUTO, 1'b1);
    for (int k = 0; k < 3; k++) cyc("autoen", MODE_AUTO, (k != 1));

    // reset while mid-AUTO, then AUTO must restart from a full divide period
    #2 rst = 1'b1;
    @(negedge clkm);
    rst = 1'b0;
    m_reset();
    check_all("arst2");
    cyc("load2", MODE_LOAD, 1'b1, 0, 0, 32'hFEDC_BA98);
    for (int k = 0; k < 5; k++) cyc("auto3", MODE_AUTO, 1'b1);

    cyc("clr", MODE_CLEAR, 1'b0);
    chk("clr.const", 64'(bus.Dout), 64'hAAAA_AAAA);

    for (int k = 0; k < 400; k++) begin
      logic [2:0] md;
      md = 3'($urandom_range(0, 7));
      if (md == MODE_CLEAR && $urandom_range(0, 3) != 0) md = MODE_AUTO;
      cyc("rand", md, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), 32'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
